// File: rtl/ring_johnson_pkg.sv
// rtl/ring_johnson_pkg.sv - shared constants and pattern helpers for the ring/Johnson sequencer
package ring_johnson_pkg;

    localparam logic RJ_RING    = 1'b0;
    localparam logic RJ_JOHNSON = 1'b1;
    localparam logic RJ_RIGHT   = 1'b0;
    localparam logic RJ_LEFT    = 1'b1;

    // Helpers work on a 32-bit container; only the low 'width' bits are meaningful.
    function automatic logic [31:0] rj_phase_zero(input logic m, input int width);
        return (m == RJ_JOHNSON) ? 32'd0 : (32'd1 << (width - 1));
    endfunction

    function automatic logic rj_is_onehot(input logic [31:0] val, input int width);
        int ones;
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < width && val[i]) ones++;
        end
        return ones == 1;
    endfunction

    function automatic logic rj_johnson_legal(input logic [31:0] val, input int width);
        int edges;
        edges = 0;
        for (int i = 0; i < 31; i++) begin
            if (i < width - 1 && val[i] != val[i+1]) edges++;
        end
        return edges <= 1;
    endfunction

endpackage

// File: rtl/rj_legal_chk.sv
// rtl/rj_legal_chk.sv - combinational legality check of the counter state for the current mode
module rj_legal_chk
    import ring_johnson_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic             mode,
    output logic             legal
);

    logic [31:0] count_ext;

    assign count_ext = 32'(count);
    assign legal = (mode == RJ_JOHNSON) ? rj_johnson_legal(count_ext, WIDTH)
                                        : rj_is_onehot(count_ext, WIDTH);

endmodule

// File: rtl/ring_johnson_cntr.sv
// rtl/ring_johnson_cntr.sv - parametrised ring/Johnson sequencer with load and self-correction
module ring_johnson_cntr
    import ring_johnson_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic RESET_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             err
);

    localparam logic [31:0] PZ_RING_32  = rj_phase_zero(RJ_RING, WIDTH);
    localparam logic [31:0] PZ_JOHN_32  = rj_phase_zero(RJ_JOHNSON, WIDTH);
    localparam logic [31:0] PZ_RESET_32 = rj_phase_zero(RESET_MODE, WIDTH);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             legal;
    logic [WIDTH-1:0] phase_zero;
    logic [WIDTH-1:0] shifted;
    logic             feedback;

    rj_legal_chk #(.WIDTH(WIDTH)) u_legal_chk (
        .count (count_q),
        .mode  (mode),
        .legal (legal)
    );

    assign phase_zero = (mode == RJ_JOHNSON) ? PZ_JOHN_32[WIDTH-1:0] : PZ_RING_32[WIDTH-1:0];

    // Johnson differs from ring only by inverting the bit that wraps around.
    always_comb begin
        feedback = 1'b0;
        shifted  = count_q;
        if (dir == RJ_LEFT) begin
            feedback = count_q[WIDTH-1] ^ mode;
            shifted  = {count_q[WIDTH-2:0], feedback};
        end else begin
            feedback = count_q[0] ^ mode;
            shifted  = {feedback, count_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (!legal) begin
                count_d = phase_zero;
                err_d   = 1'b1;
            end else begin
                count_d = shifted;
                wrap_d  = (shifted == phase_zero);
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count_q <= PZ_RESET_32[WIDTH-1:0];
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule
